// File: rtl/pcm_cap_seq_pkg.sv
// Shared definitions for the PCM capture sequencer: pcm_bffr register map,
// control-register values and the sequencer state encoding.
package pcm_cap_seq_pkg;

   localparam int LB_DATA_W_DEF = 32;
   localparam int LB_ADDR_W_DEF = 8;
   localparam int CAP_DATA_W    = 32;

   // pcm_bffr local-bus register map
   localparam logic [7:0] REG_CONTROL  = 8'h00;
   localparam logic [7:0] REG_STATUS   = 8'h01;
   localparam logic [7:0] REG_CAP_ADDR = 8'h02;

   // CONTROL register values
   localparam logic [31:0] CTRL_CAPTURE  = 32'd1;
   localparam logic [31:0] CTRL_PLAYBACK = 32'd0;

   typedef enum logic [3:0] {
      IDLE,
      MODE_ON,
      ADDR_WR,
      SETTLE,
      RD,
      RD_WAIT,
      PUSH,
      MODE_OFF,
      DONE
   } cap_state_t;

endpackage

// File: rtl/pcm_cap_seq_if.sv
// Local-bus link between the capture sequencer (master) and pcm_bffr (slave).
interface pcm_cap_seq_if
   import pcm_cap_seq_pkg::*;
#(
   parameter int LB_DATA_W = LB_DATA_W_DEF,
   parameter int LB_ADDR_W = LB_ADDR_W_DEF
) ();

   logic                 lb_wr_en;
   logic                 lb_rd_en;
   logic [LB_ADDR_W-1:0] lb_addr;
   logic [LB_DATA_W-1:0] lb_wr_data;
   logic                 lb_wr_valid;
   logic                 lb_rd_valid;
   logic [LB_DATA_W-1:0] lb_rd_data;

   modport master (
      output lb_wr_en,
      output lb_rd_en,
      output lb_addr,
      output lb_wr_data,
      input  lb_wr_valid,
      input  lb_rd_valid,
      input  lb_rd_data
   );

   modport slave (
      input  lb_wr_en,
      input  lb_rd_en,
      input  lb_addr,
      input  lb_wr_data,
      output lb_wr_valid,
      output lb_rd_valid,
      output lb_rd_data
   );

endinterface

// File: rtl/pcm_cap_seq.sv
// PCM capture sequencer: switches pcm_bffr into capture mode, walks a range
// of buffer addresses reading one PCM word per address over the local bus,
// streams each word out on a valid/ready port, then returns pcm_bffr to
// playback mode. Every bus wait is bounded by a timeout.
module pcm_cap_seq
   import pcm_cap_seq_pkg::*;
#(
   parameter int LB_DATA_W   = 32,
   parameter int LB_ADDR_W   = 8,
   parameter int NUM_SAMPLES = 128,
   parameter int RD_SETTLE   = 3,
   parameter int LB_TIMEOUT  = 16,
   localparam int MEM_ADDR_W = $clog2(NUM_SAMPLES) + 1
) (
   input  logic                  acortex_clk,
   input  logic                  acortex_rst_n,
   input  logic                  cap_start,
   input  logic                  cap_abort,
   input  logic [MEM_ADDR_W-1:0] cap_base,
   input  logic [MEM_ADDR_W:0]   cap_len,
   output logic                  cap_busy,
   output logic                  cap_done,
   output logic                  cap_err,
   pcm_cap_seq_if.master         lb,
   output logic [CAP_DATA_W-1:0] cap_data,
   output logic                  cap_valid,
   input  logic                  cap_ready
);

   localparam int CNT_W = MEM_ADDR_W + 1;
   localparam int TMO_W = (LB_TIMEOUT > 1) ? $clog2(LB_TIMEOUT) : 1;
   localparam int STL_W = (RD_SETTLE > 1) ? $clog2(RD_SETTLE) : 1;

   localparam logic [MEM_ADDR_W-1:0] ADDR_LAST = MEM_ADDR_W'(2 * NUM_SAMPLES - 1);
   localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(LB_TIMEOUT - 1);
   // at least one settle cycle is always spent
   localparam logic [STL_W-1:0]      STL_LAST  = STL_W'((RD_SETTLE > 0) ? RD_SETTLE - 1 : 0);

   cap_state_t            state;
   logic [MEM_ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]      len_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [TMO_W-1:0]      tmo_q;
   logic [STL_W-1:0]      stl_q;
   logic                  abort_pend;

   logic [CNT_W-1:0]      cnt_nxt;
   logic [MEM_ADDR_W-1:0] addr_nxt;
   logic                  abort_now;

   // next buffer address wraps over both sample banks
   function automatic logic [MEM_ADDR_W-1:0] wrap_inc(input logic [MEM_ADDR_W-1:0] a);
      if (a == ADDR_LAST) begin
         return '0;
      end
      return a + MEM_ADDR_W'(1);
   endfunction

   assign cnt_nxt   = cnt_q + CNT_W'(1);
   assign addr_nxt  = wrap_inc(addr_q);
   // an abort seen now or earlier in the current bus wait
   assign abort_now = cap_abort | abort_pend;

   // capture sequencer FSM with registered bus strobes and status outputs
   always_ff @(posedge acortex_clk or negedge acortex_rst_n) begin
      if (!acortex_rst_n) begin
         state         <= IDLE;
         addr_q        <= '0;
         len_q         <= '0;
         cnt_q         <= '0;
         tmo_q         <= '0;
         stl_q         <= '0;
         abort_pend    <= 1'b0;
         cap_busy      <= 1'b0;
         cap_done      <= 1'b0;
         cap_err       <= 1'b0;
         cap_valid     <= 1'b0;
         cap_data      <= '0;
         lb.lb_wr_en   <= 1'b0;
         lb.lb_rd_en   <= 1'b0;
         lb.lb_addr    <= '0;
         lb.lb_wr_data <= '0;
      end else begin
         // strobes and the done pulse last one cycle unless re-issued below
         lb.lb_wr_en <= 1'b0;
         lb.lb_rd_en <= 1'b0;
         cap_done    <= 1'b0;

         case (state)
            IDLE: begin
               if (cap_start) begin
                  addr_q     <= cap_base;
                  len_q      <= cap_len;
                  cnt_q      <= '0;
                  cap_err    <= 1'b0;
                  cap_busy   <= 1'b1;
                  abort_pend <= 1'b0;
                  if (cap_len == '0) begin
                     state    <= DONE;
                     cap_done <= 1'b1;
                  end else begin
                     state         <= MODE_ON;
                     lb.lb_wr_en   <= 1'b1;
                     lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                     lb.lb_wr_data <= LB_DATA_W'(CTRL_CAPTURE);
                     tmo_q         <= '0;
                  end
               end
            end

            MODE_ON, ADDR_WR: begin
               if (cap_abort) begin
                  abort_pend <= 1'b1;
               end
               if (lb.lb_wr_valid) begin
                  if (abort_now) begin
                     state         <= MODE_OFF;
                     lb.lb_wr_en   <= 1'b1;
                     lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                     lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                     tmo_q         <= '0;
                     abort_pend    <= 1'b0;
                  end else if (state == MODE_ON) begin
                     state         <= ADDR_WR;
                     lb.lb_wr_en   <= 1'b1;
                     lb.lb_addr    <= LB_ADDR_W'(REG_CAP_ADDR);
                     lb.lb_wr_data <= LB_DATA_W'(addr_q);
                     tmo_q         <= '0;
                  end else begin
                     state <= SETTLE;
                     stl_q <= '0;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  cap_err       <= 1'b1;
                  state         <= MODE_OFF;
                  lb.lb_wr_en   <= 1'b1;
                  lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                  lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                  tmo_q         <= '0;
                  abort_pend    <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end

            SETTLE: begin
               if (cap_abort) begin
                  state         <= MODE_OFF;
                  lb.lb_wr_en   <= 1'b1;
                  lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                  lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                  tmo_q         <= '0;
               end else if (stl_q == STL_LAST) begin
                  state       <= RD;
                  lb.lb_rd_en <= 1'b1;
                  lb.lb_addr  <= LB_ADDR_W'(REG_STATUS);
                  tmo_q       <= '0;
               end else begin
                  stl_q <= stl_q + STL_W'(1);
               end
            end

            // RD is the strobe cycle, RD_WAIT the remaining acknowledge wait
            RD, RD_WAIT: begin
               if (cap_abort) begin
                  abort_pend <= 1'b1;
               end
               if (lb.lb_rd_valid) begin
                  if (abort_now) begin
                     state         <= MODE_OFF;
                     lb.lb_wr_en   <= 1'b1;
                     lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                     lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                     tmo_q         <= '0;
                     abort_pend    <= 1'b0;
                  end else begin
                     cap_data  <= lb.lb_rd_data[CAP_DATA_W-1:0];
                     cap_valid <= 1'b1;
                     state     <= PUSH;
                  end
               end else if (tmo_q == TMO_LAST) begin
                  cap_err       <= 1'b1;
                  state         <= MODE_OFF;
                  lb.lb_wr_en   <= 1'b1;
                  lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                  lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                  tmo_q         <= '0;
                  abort_pend    <= 1'b0;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
                  state <= RD_WAIT;
               end
            end

            PUSH: begin
               if (cap_abort) begin
                  cap_valid     <= 1'b0;
                  state         <= MODE_OFF;
                  lb.lb_wr_en   <= 1'b1;
                  lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                  lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                  tmo_q         <= '0;
               end else if (cap_ready) begin
                  cap_valid <= 1'b0;
                  cnt_q     <= cnt_nxt;
                  if (cnt_nxt == len_q) begin
                     state         <= MODE_OFF;
                     lb.lb_wr_en   <= 1'b1;
                     lb.lb_addr    <= LB_ADDR_W'(REG_CONTROL);
                     lb.lb_wr_data <= LB_DATA_W'(CTRL_PLAYBACK);
                     tmo_q         <= '0;
                  end else begin
                     addr_q        <= addr_nxt;
                     state         <= ADDR_WR;
                     lb.lb_wr_en   <= 1'b1;
                     lb.lb_addr    <= LB_ADDR_W'(REG_CAP_ADDR);
                     lb.lb_wr_data <= LB_DATA_W'(addr_nxt);
                     tmo_q         <= '0;
                  end
               end
            end

            // returning to playback also resets the pcm_bffr write pointer
            MODE_OFF: begin
               if (lb.lb_wr_valid) begin
                  state    <= DONE;
                  cap_done <= 1'b1;
               end else if (tmo_q == TMO_LAST) begin
                  cap_err  <= 1'b1;
                  state    <= DONE;
                  cap_done <= 1'b1;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end

            DONE: begin
               cap_busy <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pcm_cap_seq.sv
// Directed bench for pcm_cap_seq with a behavioural pcm_bffr responder.
module tb_pcm_cap_seq;

   logic       acortex_clk   = 1'b0;
   logic       acortex_rst_n = 1'b1;
   logic       cap_start     = 1'b0;
   logic       cap_abort     = 1'b0;
   logic [7:0] cap_base      = '0;
   logic [8:0] cap_len       = '0;
   logic       cap_ready     = 1'b0;
   logic       drop_rd       = 1'b0;
   logic       cap_busy, cap_done, cap_err, cap_valid;
   logic [31:0] cap_data;

   int num_checks = 0;
   int num_errors = 0;

   logic [31:0] mem [256];
   logic [47:0] lb_log [$];
   logic [31:0] cap_q [$];
   int          done_cnt    = 0;
   int          viol_cnt    = 0;
   int          cyc         = 0;
   int          last_rd_cyc = 0;
   int          off_cyc     = 0;
   logic        wr_pend = 1'b0, rd_pend = 1'b0, prev_wr = 1'b0, prev_rd = 1'b0;
   logic [7:0]  bffr_ptr = '0;

   always #5 acortex_clk = ~acortex_clk;

   pcm_cap_seq_if #(.LB_DATA_W(32), .LB_ADDR_W(8)) lb_bus ();

   pcm_cap_seq dut (
      .acortex_clk   (acortex_clk),
      .acortex_rst_n (acortex_rst_n),
      .cap_start     (cap_start),
      .cap_abort     (cap_abort),
      .cap_base      (cap_base),
      .cap_len       (cap_len),
      .cap_busy      (cap_busy),
      .cap_done      (cap_done),
      .cap_err       (cap_err),
      .lb            (lb_bus),
      .cap_data      (cap_data),
      .cap_valid     (cap_valid),
      .cap_ready     (cap_ready)
   );

   // pcm_bffr responder and bus/output monitor, sampled mid-cycle
   always @(negedge acortex_clk) begin
      cyc <= cyc + 1;
      if (!acortex_rst_n) begin
         lb_bus.lb_wr_valid <= 1'b0;
         lb_bus.lb_rd_valid <= 1'b0;
         lb_bus.lb_rd_data  <= '0;
         wr_pend  <= 1'b0;
         rd_pend  <= 1'b0;
         prev_wr  <= 1'b0;
         prev_rd  <= 1'b0;
         bffr_ptr <= '0;
      end else begin
         lb_bus.lb_wr_valid <= wr_pend;
         lb_bus.lb_rd_valid <= rd_pend && !drop_rd;
         if (rd_pend) lb_bus.lb_rd_data <= mem[bffr_ptr];
         wr_pend <= lb_bus.lb_wr_en;
         rd_pend <= lb_bus.lb_rd_en;
         prev_wr <= lb_bus.lb_wr_en;
         prev_rd <= lb_bus.lb_rd_en;
         if (lb_bus.lb_wr_en) begin
            lb_log.push_back({8'h01, lb_bus.lb_addr, lb_bus.lb_wr_data});
            if (lb_bus.lb_addr == 8'h02) bffr_ptr <= lb_bus.lb_wr_data[7:0];
            if (lb_bus.lb_addr == 8'h00 && lb_bus.lb_wr_data == 32'd0) off_cyc <= cyc;
         end
         if (lb_bus.lb_rd_en) begin
            lb_log.push_back({8'h02, lb_bus.lb_addr, 32'h0});
            last_rd_cyc <= cyc;
         end
         if ((lb_bus.lb_wr_en && lb_bus.lb_rd_en) || (lb_bus.lb_wr_en && prev_wr) ||
             (lb_bus.lb_rd_en && prev_rd))
            viol_cnt <= viol_cnt + 1;
         if (cap_done) done_cnt <= done_cnt + 1;
         if (cap_valid && cap_ready) cap_q.push_back(cap_data);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] wr_e(input logic [7:0] a, input logic [31:0] d);
      return {8'h01, a, d};
   endfunction

   function automatic logic [47:0] rd_e();
      return {8'h02, 8'h01, 32'h0};
   endfunction

   task automatic tick();
      @(posedge acortex_clk);
      #1;
   endtask

   task automatic start_cap(input logic [7:0] base, input logic [8:0] len, input logic with_abort);
      cap_base  = base;
      cap_len   = len;
      cap_start = 1'b1;
      cap_abort = with_abort;
      tick();
      cap_start = 1'b0;
      cap_abort = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int d0);
      int k = 0;
      while (done_cnt == d0 && k < 2000) begin
         tick();
         k++;
      end
      repeat (3) tick();
      check({tag, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
      check({tag, "_busy_low"}, 64'(cap_busy), 64'd0);
   endtask

   task automatic wait_log(input string tag, input int n);
      int k = 0;
      while (lb_log.size() < n && k < 500) begin
         tick();
         k++;
      end
      check({tag, "_log_reached"}, 64'(lb_log.size() >= n), 64'd1);
   endtask

   task automatic check_log(input string tag, input int base, input logic [47:0] exp [$]);
      logic [47:0] got;
      check({tag, "_log_len"}, 64'(lb_log.size() - base), 64'(exp.size()));
      foreach (exp[i]) begin
         got = (base + i < lb_log.size()) ? lb_log[base + i] : '1;
         check($sformatf("%s_log%0d", tag, i), 64'(got), 64'(exp[i]));
      end
   endtask

   task automatic check_caps(input string tag, input int base, input logic [31:0] exp [$]);
      logic [31:0] got;
      check({tag, "_cap_cnt"}, 64'(cap_q.size() - base), 64'(exp.size()));
      foreach (exp[i]) begin
         got = (base + i < cap_q.size()) ? cap_q[base + i] : '1;
         check($sformatf("%s_cap%0d", tag, i), 64'(got), 64'(exp[i]));
      end
   endtask

   initial begin
      int lb0, cq0, d0, k;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA0 + 32'(i);

      #1 acortex_rst_n = 1'b0;
      repeat (3) tick();
      check("rst_busy",  64'(cap_busy),  64'd0);
      check("rst_done",  64'(cap_done),  64'd0);
      check("rst_err",   64'(cap_err),   64'd0);
      check("rst_valid", 64'(cap_valid), 64'd0);
      check("rst_strb",  64'({lb_bus.lb_wr_en, lb_bus.lb_rd_en}), 64'd0);
      check("rst_addr",  64'(lb_bus.lb_addr), 64'd0);
      check("rst_wdata", 64'(lb_bus.lb_wr_data), 64'd0);
      check("rst_cdata", 64'(cap_data), 64'd0);
      acortex_rst_n = 1'b1;
      repeat (2) tick();

      // four words from base 0; start with abort in IDLE, restart while busy
      cap_ready = 1'b1;
      lb0 = lb_log.size(); cq0 = cap_q.size(); d0 = done_cnt;
      start_cap(8'h00, 9'd4, 1'b1);
      check("t1_busy", 64'(cap_busy), 64'd1);
      repeat (5) tick();
      start_cap(8'h40, 9'd1, 1'b0);
      wait_done("t1", d0);
      check_log("t1", lb0, {wr_e(8'h00, 32'd1), wr_e(8'h02, 32'd0), rd_e(), wr_e(8'h02, 32'd1), rd_e(),
                            wr_e(8'h02, 32'd2), rd_e(), wr_e(8'h02, 32'd3), rd_e(), wr_e(8'h00, 32'd0)});
      check_caps("t1", cq0, {32'hA0, 32'hA1, 32'hA2, 32'hA3});
      check("t1_err", 64'(cap_err), 64'd0);

      // wrap from the last buffer address back to 0
      lb0 = lb_log.size(); cq0 = cap_q.size(); d0 = done_cnt;
      start_cap(8'hFF, 9'd3, 1'b0);
      wait_done("t2", d0);
      check_log("t2", lb0, {wr_e(8'h00, 32'd1), wr_e(8'h02, 32'hFF), rd_e(), wr_e(8'h02, 32'h00), rd_e(),
                            wr_e(8'h02, 32'h01), rd_e(), wr_e(8'h00, 32'd0)});
      check_caps("t2", cq0, {32'h19F, 32'hA0, 32'hA1});

      // downstream back-pressure holds the word and the bus
      cap_ready = 1'b0;
      lb0 = lb_log.size(); cq0 = cap_q.size(); d0 = done_cnt;
      start_cap(8'h00, 9'd2, 1'b0);
      k = 0;
      while (!cap_valid && k < 200) begin tick(); k++; end
      check("t3_valid_seen", 64'(cap_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("t3_hold%0d", i), 64'({cap_valid, cap_data}), {31'd0, 1'b1, 32'hA0});
      end
      check("t3_no_lb", 64'(lb_log.size() - lb0), 64'd3);
      cap_ready = 1'b1;
      wait_done("t3", d0);
      check_caps("t3", cq0, {32'hA0, 32'hA1});

      // read acknowledge never returns
      drop_rd = 1'b1;
      lb0 = lb_log.size(); cq0 = cap_q.size(); d0 = done_cnt;
      start_cap(8'h00, 9'd2, 1'b0);
      wait_done("t4", d0);
      drop_rd = 1'b0;
      check("t4_err", 64'(cap_err), 64'd1);
      check("t4_tmo_gap", 64'(off_cyc - last_rd_cyc), 64'd16);
      check_log("t4", lb0, {wr_e(8'h00, 32'd1), wr_e(8'h02, 32'd0), rd_e(), wr_e(8'h00, 32'd0)});
      check("t4_caps", 64'(cap_q.size() - cq0), 64'd0);

      // abort while settling the second of eight words
      lb0 = lb_log.size(); cq0 = cap_q.size(); d0 = done_cnt;
      start_cap(8'h00, 9'd8, 1'b0);
      check("t5_err_clr", 64'(cap_err), 64'd0);
      wait_log("t5", lb0 + 4);
      tick();
      cap_abort = 1'b1;
      tick();
      cap_abort = 1'b0;
      wait_done("t5", d0);
      check_log("t5", lb0, {wr_e(8'h00, 32'd1), wr_e(8'h02, 32'd0), rd_e(), wr_e(8'h02, 32'd1),
                            wr_e(8'h00, 32'd0)});
      check_caps("t5", cq0, {32'hA0});

      // zero-length request finishes without bus traffic
      lb0 = lb_log.size(); d0 = done_cnt;
      start_cap(8'h10, 9'd0, 1'b0);
      wait_done("t6", d0);
      check("t6_no_lb", 64'(lb_log.size() - lb0), 64'd0);

      // reset while waiting for read data, then a normal capture
      lb0 = lb_log.size();
      start_cap(8'h00, 9'd4, 1'b0);
      wait_log("t7", lb0 + 3);
      acortex_rst_n = 1'b0;
      #1;
      check("t7_rst_ctl", 64'({cap_busy, cap_done, cap_err, cap_valid, lb_bus.lb_wr_en, lb_bus.lb_rd_en}), 64'd0);
      check("t7_rst_bus", 64'({lb_bus.lb_addr, lb_bus.lb_wr_data}), 64'd0);
      check("t7_rst_cdata", 64'(cap_data), 64'd0);
      repeat (2) tick();
      acortex_rst_n = 1'b1;
      repeat (2) tick();
      lb0 = lb_log.size(); cq0 = cap_q.size(); d0 = done_cnt;
      start_cap(8'h05, 9'd1, 1'b0);
      wait_done("t7", d0);
      check_log("t7", lb0, {wr_e(8'h00, 32'd1), wr_e(8'h02, 32'd5), rd_e(), wr_e(8'h00, 32'd0)});
      check_caps("t7", cq0, {32'hA5});

      check("strobe_rules", 64'(viol_cnt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
